// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter: round-robin shares one serial "1001" Mealy detector between two word requesters,
// shifting each granted word MSB-first and reporting its match count and requester ID.
module seq_detect_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             w_out,
  output logic             z_out,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int BW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;
  state_t           state_q;
  det_t             det_q, det_d;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic             last_id_q, cur_id_q, done_q, done_id_q, pick1;
  // On contention the requester that was not served last wins
  assign pick1 = req1 && (!req0 || !last_id_q);
  assign gnt0 = rst && state_q == IDLE && req0 && !pick1;
  assign gnt1 = rst && state_q == IDLE && pick1;
  assign busy = state_q != IDLE;
  assign w_out = rst && state_q == SHIFT && shreg_q[WIDTH-1];
  assign z_out = w_out && det_q == S3;
  assign done = done_q;
  assign done_id = done_id_q;
  assign match_cnt = match_cnt_q;
  always_comb
    det_d = w_out ? S1 : det_q == S1 ? S2 : det_q == S2 ? S3 : S0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      det_q       <= S0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      last_id_q   <= 1'b1;
      cur_id_q    <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (gnt0 || gnt1) begin
          shreg_q     <= gnt1 ? data1 : data0;
          cur_id_q    <= gnt1;
          last_id_q   <= gnt1;
          det_q       <= S0;
          bit_cnt_q   <= '0;
          match_cnt_q <= '0;
          state_q     <= SHIFT;
        end
        SHIFT: begin
          shreg_q     <= shreg_q << 1;
          det_q       <= det_d;
          bit_cnt_q   <= bit_cnt_q + 1'b1;
          match_cnt_q <= match_cnt_q + CNT_W'(z_out && !(&match_cnt_q));
          if (bit_cnt_q == BW'(WIDTH - 1)) begin
            state_q   <= FIN;
            done_q    <= 1'b1;
            done_id_q <= cur_id_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
